mem_pipe_responder: RTL and testbench

- Single-port memory responder: the target end of the val/rdy memory request/response interface that the PARCv2 core drives on its imem and dmem ports.
- Accepts one request per cycle, performs the read or write on an internal word array, and returns the response exactly LATENCY cycles later.
- Responses are buffered so the initiator may backpressure via memresp_rdy without losing data.
- Intended for integration harnesses where a fixed-latency, pipelined memory replaces a random-delay test memory.

---
 rtl/vc_mem_msgs_pkg.sv | 39 +++
 rtl/mem_resp_fifo.sv | 58 +++++
 rtl/mem_pipe_responder.sv | 142 ++++++++++++++
 tb/tb_mem_pipe_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_mem_msgs_pkg.sv
// Field layout, type codes and read-alignment helper for the val/rdy memory request/response messages.
// Request {type, addr, len, data} is 67 bits; response {type, len, data} is 35 bits.
package vc_mem_msgs;

  localparam int REQ_SZ       = 67;
  localparam int RESP_SZ      = 35;
  localparam int REQ_TYPE_BIT = 66;
  localparam int REQ_ADDR_LSB = 34;
  localparam int REQ_LEN_LSB  = 32;
  localparam int REQ_DATA_LSB = 0;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
  } resp_t;

  // len 0 returns the whole word unshifted; otherwise the addressed bytes, zero-extended.
  function automatic logic [31:0] read_align(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  len);
    logic [31:0] sh;
    if (len == 2'd0) begin
      sh = word;
    end else begin
      sh = word >> {off, 3'b000};
      case (len)
        2'd1:    sh = {24'd0, sh[7:0]};
        2'd2:    sh = {16'd0, sh[15:0]};
        default: sh = {8'd0, sh[23:0]};
      endcase
    end
    return sh;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Circular val/rdy FIFO with registered count; head data is read straight from storage.
// Pointers wrap modulo p_depth, so the depth need not be a power of two.
module mem_resp_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 35,
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1,
  localparam int CW = $clog2(p_depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_width-1:0] enq_msg_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_width-1:0] deq_msg_o,
  output logic [CW-1:0]      count_o
);

  logic [p_width-1:0] buf_q [p_depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               enq, deq;

  assign enq_rdy_o = (count_q != CW'(p_depth));
  assign deq_val_o = (count_q != '0);
  assign deq_msg_o = buf_q[rd_ptr_q];
  assign count_o   = count_q;
  assign enq       = enq_val_i && enq_rdy_o;
  assign deq       = deq_val_o && deq_rdy_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == PW'(p_depth - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = (rd_ptr_q == PW'(p_depth - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (!enq && deq) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) buf_q[wr_ptr_q] <= enq_msg_i;
  end

endmodule

// File: rtl/mem_pipe_responder.sv
// Fixed-latency pipelined memory target: access at the request handshake, response p_latency cycles later.
// Credit count (pipeline + FIFO) gates memreq_rdy so the never-stalling delay line cannot overflow the FIFO.
module mem_pipe_responder
  import vc_mem_msgs::*;
#(
  parameter int p_mem_sz  = 1 << 16,
  parameter int p_addr_sz = 32,
  parameter int p_data_sz = 32,
  parameter int p_latency = 2,
  parameter int p_qdepth  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memreq_val,
  output logic               memreq_rdy,
  input  logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memresp_val,
  input  logic               memresp_rdy,
  output logic [RESP_SZ-1:0] memresp_msg
);

  localparam int AW     = $clog2(p_mem_sz);
  localparam int NWORDS = p_mem_sz / 4;
  localparam int CW     = $clog2(p_qdepth + 1);

  logic [31:0]          mem_q [NWORDS];
  logic                 req_typ;
  logic [p_addr_sz-1:0] req_addr;
  logic [1:0]           req_len, off;
  logic [p_data_sz-1:0] req_data;
  logic [AW-3:0]        word_idx;
  logic                 accept, pop;
  resp_t                resp_now, enq_msg;
  logic                 enq_val;
  logic [3:0]           lane_we;
  logic [31:0]          wr_shift;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 memreq_rdy_q;
  logic [RESP_SZ-1:0]   resp_hold_q, fifo_deq_msg;
  logic                 fifo_enq_rdy;
  logic [CW-1:0]        fifo_count;
  logic                 unused_ok;

  assign req_typ  = memreq_msg[REQ_TYPE_BIT];
  assign req_addr = memreq_msg[REQ_ADDR_LSB +: p_addr_sz];
  assign req_len  = memreq_msg[REQ_LEN_LSB +: 2];
  assign req_data = memreq_msg[REQ_DATA_LSB +: p_data_sz];
  assign word_idx = req_addr[AW-1:2];
  assign off      = req_addr[1:0];
  assign unused_ok = ^{req_addr[p_addr_sz-1:AW], fifo_enq_rdy, fifo_count};

  assign memreq_rdy = memreq_rdy_q;
  assign accept     = memreq_val && memreq_rdy_q;
  assign pop        = memresp_val && memresp_rdy;

  always_comb begin
    resp_now.typ  = req_typ;
    resp_now.len  = req_len;
    resp_now.data = (req_typ == MEM_READ) ? read_align(mem_q[word_idx], off, req_len) : '0;
  end

  // Lanes beyond 3 simply fall off the end; no carry into the next word.
  always_comb begin
    logic [3:0] lane_end;
    lane_end = {2'b00, off} + ((req_len == 2'd0) ? 4'd4 : {2'b00, req_len});
    wr_shift = 32'(req_data) << {off, 3'b000};
    lane_we  = '0;
    for (int i = 0; i < 4; i++) begin
      lane_we[i] = (i >= int'(off)) && (i < int'(lane_end));
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_typ == MEM_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem_q[word_idx][8*i +: 8] <= wr_shift[8*i +: 8];
      end
    end
  end

  if (p_latency == 1) begin : g_lat1
    assign enq_val = accept;
    assign enq_msg = resp_now;
  end else begin : g_pipe
    logic [p_latency-2:0] pipe_val_q;
    resp_t                pipe_msg_q [p_latency-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe_val_q <= '0;
        for (int s = 0; s < p_latency - 1; s++) pipe_msg_q[s] <= '0;
      end else begin
        pipe_val_q[0] <= accept;
        pipe_msg_q[0] <= accept ? resp_now : '0;
        for (int s = 1; s < p_latency - 1; s++) begin
          pipe_val_q[s] <= pipe_val_q[s-1];
          pipe_msg_q[s] <= pipe_msg_q[s-1];
        end
      end
    end

    assign enq_val = pipe_val_q[p_latency-2];
    assign enq_msg = pipe_msg_q[p_latency-2];
  end

  mem_resp_fifo #(
    .p_depth (p_qdepth),
    .p_width (RESP_SZ)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (enq_val),
    .enq_rdy_o (fifo_enq_rdy),
    .enq_msg_i (enq_msg),
    .deq_val_o (memresp_val),
    .deq_rdy_i (memresp_rdy),
    .deq_msg_o (fifo_deq_msg),
    .count_o   (fifo_count)
  );

  // Output holds the last head seen while the FIFO is empty.
  assign memresp_msg = memresp_val ? fifo_deq_msg : resp_hold_q;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      memreq_rdy_q <= 1'b0;
      resp_hold_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      memreq_rdy_q <= (cnt_d < CW'(p_qdepth));
      if (memresp_val) resp_hold_q <= fifo_deq_msg;
    end
  end

endmodule

// File: tb/tb_mem_pipe_responder.sv
// Bench for mem_pipe_responder: table-driven read/write vectors plus backpressure, throughput and reset sequences.
// Expected responses are queued at request acceptance and compared in order as the DUT returns them.
module tb_mem_pipe_responder;
  import vc_mem_msgs::*;

  localparam int LAT   = 2;
  localparam int QD    = 4;
  localparam int LIMIT = 200;

  logic               clk;
  logic               reset;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [REQ_SZ-1:0]  memreq_msg;
  logic               memresp_val;
  logic               memresp_rdy;
  logic [RESP_SZ-1:0] memresp_msg;

  mem_pipe_responder #(
    .p_mem_sz  (1 << 16),
    .p_addr_sz (32),
    .p_data_sz (32),
    .p_latency (LAT),
    .p_qdepth  (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RESP_SZ-1:0] resp;
    int                 acc;
  } exp_t;

  typedef struct {
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[20];
  logic [31:0] bp_addr[4];
  logic [31:0] bp_data[4];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pops     = 0;
  int          stalls   = 0;
  logic        lat_chk  = 1'b1;
  logic        head_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Response monitor / scoreboard
  always begin
    @(negedge clk);
    #1;
    if (memresp_val) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_spurious actual=%h required=none", memresp_msg);
      end else begin
        if (!head_seen && lat_chk) chk("resp_latency", 64'(cyc - exp_q[0].acc), 64'(LAT - 1));
        head_seen = 1'b1;
        if (memresp_rdy) begin
          chk("resp_msg", 64'(memresp_msg), 64'(exp_q[0].resp));
          void'(exp_q.pop_front());
          head_seen = 1'b0;
          pops++;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (reset && dut.u_fifo.enq_val_i && !dut.u_fifo.enq_rdy_o) begin
      checks++;
      failures++;
      $display("FAIL fifo_overflow actual=enq_into_full required=no_enq");
    end
  end

  task automatic idle_msg();
    memreq_val = 1'b0;
    memreq_msg = {$urandom(), $urandom(), 3'($urandom())};
  endtask

  // Called just after a negedge; returns one negedge after the accepting edge.
  task automatic send(input logic typ, input logic [31:0] addr, input logic [1:0] len,
                      input logic [31:0] data, input logic [31:0] exp_data);
    int   n;
    exp_t e;
    memreq_val = 1'b1;
    memreq_msg = {typ, addr, len, data};
    n = 0;
    while (!memreq_rdy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n != 0) stalls++;
    if (!memreq_rdy) begin
      chk("req_accept_timeout", 64'(memreq_rdy), 64'd1);
    end else begin
      e.resp = {typ, len, exp_data};
      e.acc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    idle_msg();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int pops0;
    vecs[0]  = '{MEM_WRITE, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{MEM_READ,  32'h0000_0100, 2'd0, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{MEM_WRITE, 32'h0000_0100, 2'd0, 32'h1122_3344, 32'h0};
    vecs[3]  = '{MEM_WRITE, 32'h0000_0103, 2'd1, 32'h0000_00AB, 32'h0};
    vecs[4]  = '{MEM_READ,  32'h0000_0100, 2'd0, 32'h0,         32'hAB22_3344};
    vecs[5]  = '{MEM_READ,  32'h0000_0102, 2'd2, 32'h0,         32'h0000_AB22};
    vecs[6]  = '{MEM_WRITE, 32'h0000_0200, 2'd0, 32'h5566_7788, 32'h0};
    vecs[7]  = '{MEM_WRITE, 32'h0000_0201, 2'd2, 32'h1234_ABCD, 32'h0};
    vecs[8]  = '{MEM_READ,  32'h0000_0200, 2'd0, 32'h0,         32'h55AB_CD88};
    vecs[9]  = '{MEM_WRITE, 32'h0000_020C, 2'd0, 32'h0,         32'h0};
    vecs[10] = '{MEM_WRITE, 32'h0000_0210, 2'd0, 32'h1234_5678, 32'h0};
    vecs[11] = '{MEM_WRITE, 32'h0000_020E, 2'd3, 32'h00C0_FFEE, 32'h0};
    vecs[12] = '{MEM_READ,  32'h0000_020C, 2'd0, 32'h0,         32'hFFEE_0000};
    vecs[13] = '{MEM_READ,  32'h0000_0210, 2'd0, 32'h0,         32'h1234_5678};
    vecs[14] = '{MEM_READ,  32'h0000_020D, 2'd3, 32'h0,         32'h00FF_EE00};
    vecs[15] = '{MEM_READ,  32'h0000_0203, 2'd1, 32'h0,         32'h0000_0055};
    vecs[16] = '{MEM_READ,  32'h0000_0201, 2'd0, 32'h0,         32'h55AB_CD88};
    vecs[17] = '{MEM_WRITE, 32'h0001_0100, 2'd0, 32'hCAFE_F00D, 32'h0};
    vecs[18] = '{MEM_READ,  32'h0000_0100, 2'd0, 32'h0,         32'hCAFE_F00D};
    vecs[19] = '{MEM_READ,  32'h0001_0200, 2'd1, 32'h0,         32'h0000_0088};
    bp_addr[0] = 32'h200; bp_data[0] = 32'h55AB_CD88;
    bp_addr[1] = 32'h20C; bp_data[1] = 32'hFFEE_0000;
    bp_addr[2] = 32'h210; bp_data[2] = 32'h1234_5678;
    bp_addr[3] = 32'h100; bp_data[3] = 32'hCAFE_F00D;

    // Reset then idle
    reset       = 1'b0;
    memresp_rdy = 1'b1;
    idle_msg();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_rdy", 64'(memreq_rdy), 64'd0);
      chk("rst_resp_val", 64'(memresp_val), 64'd0);
      chk("rst_resp_msg", 64'(memresp_msg), 64'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_rdy", 64'(memreq_rdy), 64'd1);
    chk("post_rst_resp_val", 64'(memresp_val), 64'd0);
    @(negedge clk);

    // Table-driven read/write vectors, unloaded latency checked per response
    for (int i = 0; i < 20; i++) begin
      send(vecs[i].typ, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].exp);
    end
    drain("table_drain");

    // Backpressure: exactly QD accepted while memresp_rdy is low
    lat_chk     = 1'b0;
    memresp_rdy = 1'b0;
    acc         = 0;
    pops0       = pops;
    memreq_val  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      memreq_msg = {MEM_READ, bp_addr[acc % 4], 2'd0, 32'h0};
      if (memreq_rdy) begin
        exp_q.push_back('{{MEM_READ, 2'd0, bp_data[acc % 4]}, cyc + 1});
        acc++;
      end
      @(negedge clk);
    end
    idle_msg();
    chk("bp_accepts", 64'(acc), 64'(QD));
    chk("bp_req_rdy_low", 64'(memreq_rdy), 64'd0);
    chk("bp_resp_val_held", 64'(memresp_val), 64'd1);
    memresp_rdy = 1'b1;
    drain("bp_drain");
    chk("bp_pops", 64'(pops - pops0), 64'(QD));
    chk("bp_req_rdy_back", 64'(memreq_rdy), 64'd1);
    chk("empty_resp_val", 64'(memresp_val), 64'd0);
    chk("empty_msg_hold", 64'(memresp_msg), 64'({MEM_READ, 2'd0, bp_data[3]}));
    lat_chk = 1'b1;

    // Throughput: 100 back-to-back reads, no stalls, latency checked on every response
    stalls = 0;
    pops0  = pops;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) send(MEM_READ, 32'h100, 2'd0, 32'h0, 32'hCAFE_F00D);
      else            send(MEM_READ, 32'h200, 2'd0, 32'h0, 32'h55AB_CD88);
    end
    drain("tput_drain");
    chk("tput_stalls", 64'(stalls), 64'd0);
    chk("tput_pops", 64'(pops - pops0), 64'd100);

    // Reset mid-flight: queued/in-flight responses vanish, memory survives
    memresp_rdy = 1'b0;
    lat_chk     = 1'b0;
    for (int i = 0; i < 3; i++) send(MEM_READ, 32'h210, 2'd0, 32'h0, 32'h1234_5678);
    reset = 1'b0;
    exp_q.delete();
    head_seen = 1'b0;
    @(negedge clk);
    chk("midrst_req_rdy", 64'(memreq_rdy), 64'd0);
    reset       = 1'b1;
    memresp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_resp_val", 64'(memresp_val), 64'd0);
    end
    chk("midrst_resp_msg", 64'(memresp_msg), 64'd0);
    lat_chk = 1'b1;
    send(MEM_READ, 32'h200, 2'd0, 32'h0, 32'h55AB_CD88);
    send(MEM_READ, 32'h201, 2'd2, 32'h0, 32'h0000_ABCD);
    drain("midrst_drain");

    repeat (3) @(negedge clk);
    chk("final_resp_val", 64'(memresp_val), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
